io_pwr_seq: RTL

Digital power-up sequencer for one IO supply segment, consuming the supply-good indication of the segment powered through the VSUP/VDDIO supply pad. It synchronises and debounces the asynchronous supply-good flag, then releases pad isolation, pad output enable and IO-domain reset in a fixed, timed order. On supply loss it forces every pad of the segment back to the safe state. It sits in the always-on core domain between the IO ring supply cells and the pad-ring control logic.

---
 rtl/io_pwr_pkg.sv | 38 +++
 rtl/io_pwr_sync2.sv | 23 ++
 rtl/io_pwr_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/io_pwr_pkg.sv
// Shared types for the IO supply power-up sequencer: FSM state encoding
// and the per-state pad control decode.
package io_pwr_pkg;

    typedef enum logic [2:0] {
        OFF,
        DEB,
        ISO_REL,
        OE_EN,
        RST_REL,
        READY
    } io_pwr_state_e;

    typedef struct packed {
        logic pad_iso_n;
        logic pad_oe_en;
        logic io_rst_n;
        logic io_ready;
    } io_pwr_out_t;

    localparam io_pwr_out_t OUT_OFF     = 4'b0000;
    localparam io_pwr_out_t OUT_ISO_REL = 4'b1000;
    localparam io_pwr_out_t OUT_OE_EN   = 4'b1100;
    localparam io_pwr_out_t OUT_RST_REL = 4'b1110;
    localparam io_pwr_out_t OUT_READY   = 4'b1111;

    // OFF and DEB both hold every pad in the safe state.
    function automatic io_pwr_out_t state_outs(input io_pwr_state_e s);
        case (s)
            ISO_REL: return OUT_ISO_REL;
            OE_EN:   return OUT_OE_EN;
            RST_REL: return OUT_RST_REL;
            READY:   return OUT_READY;
            default: return OUT_OFF;
        endcase
    endfunction

endpackage

// File: rtl/io_pwr_sync2.sv
// Two-flop synchroniser bringing the IO-domain supply-good flag into the
// always-on core clock domain. Resets to 0 (supply treated as absent).
module io_pwr_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // CDC waiver: d is asynchronous by design; meta_q is the metastability stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/io_pwr_seq.sv
// Power-up sequencer for one IO supply segment: debounces the supply-good
// flag, then releases isolation, output enable and IO reset in timed order.
module io_pwr_seq
    import io_pwr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int STEP_CYCLES     = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vsup_ok,
    input  logic en,
    input  logic fault_clr,
    output logic pad_iso_n,
    output logic pad_oe_en,
    output logic io_rst_n,
    output logic io_ready,
    output logic fault
);

    localparam int CNT_MAX = (DEBOUNCE_CYCLES > STEP_CYCLES) ? DEBOUNCE_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);

    io_pwr_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fault_q, fault_d, fault_set;
    logic             vsup_s;
    io_pwr_out_t      outs;

    io_pwr_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (vsup_ok),
        .q     (vsup_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fault_set = 1'b0;
        if (!vsup_s || !en) begin
            // Supply loss only counts as a fault once pads may be driving.
            state_d   = OFF;
            fault_set = !vsup_s && (state_q == OE_EN || state_q == RST_REL || state_q == READY);
        end else begin
            case (state_q)
                OFF:     state_d = DEB;
                DEB:     if (cnt_q == DEB_LAST)  state_d = ISO_REL; else cnt_d = cnt_q + 1'b1;
                ISO_REL: if (cnt_q == STEP_LAST) state_d = OE_EN;   else cnt_d = cnt_q + 1'b1;
                OE_EN:   if (cnt_q == STEP_LAST) state_d = RST_REL; else cnt_d = cnt_q + 1'b1;
                RST_REL: if (cnt_q == STEP_LAST) state_d = READY;   else cnt_d = cnt_q + 1'b1;
                READY:   state_d = READY;
                default: state_d = OFF;
            endcase
        end
        if (state_d != state_q) cnt_d = '0;
        fault_d = fault_set | (fault_q & ~fault_clr);
    end

    assign outs      = state_outs(state_q);
    assign pad_iso_n = outs.pad_iso_n;
    assign pad_oe_en = outs.pad_oe_en;
    assign io_rst_n  = outs.io_rst_n;
    assign io_ready  = outs.io_ready;
    assign fault     = fault_q;

endmodule
